// File: rtl/door_motor_if.sv
// Command/feedback bundle between the door controller FSM and the motor driver.
interface door_motor_if #(
    parameter int POS_BITS = 10
) ();
    logic                mo;
    logic                mc;
    logic                ms;
    logic                enc_pulse;
    logic                pwm;
    logic                dir;
    logic                brake;
    logic                door_opened;
    logic                door_closed;
    logic                fault;
    logic [POS_BITS-1:0] position;

    // Controller / encoder side
    modport master (
        output mo, mc, ms, enc_pulse,
        input  pwm, dir, brake, door_opened, door_closed, fault, position
    );

    // Motor driver side
    modport slave (
        input  mo, mc, ms, enc_pulse,
        output pwm, dir, brake, door_opened, door_closed, fault, position
    );
endinterface

// File: rtl/door_motor_driver.sv
// Sliding-door motor driver: ramped PWM, reversal dead time, encoder position
// tracking with limit stop, and sticky stall fault.
module door_motor_driver #(
    parameter int PWM_BITS     = 8,
    parameter int DUTY_MAX     = 255,
    parameter int RAMP_STEP    = 16,
    parameter int RAMP_DIV     = 64,
    parameter int DEAD_CYCLES  = 32,
    parameter int POS_BITS     = 10,
    parameter int POS_OPEN     = 1000,
    parameter int STALL_CYCLES = 4096
) (
    input logic         clk,
    input logic         rst,
    door_motor_if.slave bus
);
    localparam int RW = $clog2(RAMP_DIV + 1);
    localparam int DW = $clog2(DEAD_CYCLES + 1);
    localparam int SW = $clog2(STALL_CYCLES + 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] DEAD  = 3'd1;
    localparam logic [2:0] ACCEL = 3'd2;
    localparam logic [2:0] RUN   = 3'd3;
    localparam logic [2:0] DECEL = 3'd4;
    localparam logic [2:0] FAULT = 3'd5;

    localparam logic [PWM_BITS-1:0] D_MAX  = PWM_BITS'(DUTY_MAX);
    localparam logic [PWM_BITS-1:0] D_STEP = PWM_BITS'(RAMP_STEP);
    localparam logic [POS_BITS-1:0] P_OPEN = POS_BITS'(POS_OPEN);
    localparam logic [RW-1:0]       R_LAST = RW'(RAMP_DIV - 1);
    localparam logic [DW-1:0]       D_LAST = DW'(DEAD_CYCLES - 1);
    localparam logic [SW-1:0]       S_LAST = SW'(STALL_CYCLES - 1);

    logic [2:0]          state, state_n;
    logic [PWM_BITS-1:0] duty, duty_n, cnt, cnt_n;
    logic [RW-1:0]       ramp_cnt, ramp_n;
    logic [DW-1:0]       dead_cnt, dead_n;
    logic [SW-1:0]       stall_cnt, stall_n;
    logic [POS_BITS-1:0] position, pos_n;
    logic                pwm, dir, dir_n, brake, brake_n, fault, fault_n;
    logic                door_opened, door_closed;
    logic                req_valid, req_dir, ramp_tick, limit_hit, stall_hit;
    logic [PWM_BITS:0]   duty_up;

    // mo+mc together means no command; ms is handled separately with top priority
    assign req_valid = bus.mo ^ bus.mc;
    assign req_dir   = bus.mo;
    assign ramp_tick = (ramp_cnt == R_LAST);
    assign duty_up   = {1'b0, duty} + {1'b0, D_STEP};
    assign cnt_n     = cnt + 1'b1;

    // Next-state logic; later overrides implement the event priority order
    always_comb begin
        state_n = state;
        duty_n  = duty;
        dir_n   = dir;
        brake_n = brake;
        fault_n = fault;
        ramp_n  = ramp_cnt;
        dead_n  = dead_cnt;
        stall_n = stall_cnt;
        pos_n   = position;
        case (state)
            IDLE: begin
                duty_n  = '0;
                brake_n = 1'b1;
                // a command toward an already reached limit is dropped
                if (!bus.ms && req_valid && (req_dir ? position != P_OPEN : position != '0)) begin
                    dir_n   = req_dir;
                    brake_n = 1'b0;
                    dead_n  = '0;
                    state_n = DEAD;
                end
            end
            DEAD: begin
                duty_n  = '0;
                brake_n = 1'b0;
                if (bus.ms || !req_valid) begin
                    brake_n = 1'b1;
                    state_n = IDLE;
                end else if (req_dir != dir) begin
                    dir_n  = req_dir;
                    dead_n = '0;
                end else if (dead_cnt == D_LAST) begin
                    ramp_n  = '0;
                    stall_n = '0;
                    state_n = ACCEL;
                end else begin
                    dead_n = dead_cnt + 1'b1;
                end
            end
            ACCEL, RUN: begin
                stall_n = stall_cnt + 1'b1;
                if (bus.ms) begin
                    duty_n  = '0;
                    brake_n = 1'b1;
                    state_n = IDLE;
                end else if (!req_valid || req_dir != dir) begin
                    ramp_n  = '0;
                    state_n = DECEL;
                end else if (state == ACCEL) begin
                    if (ramp_tick) begin
                        ramp_n = '0;
                        if (duty_up >= {1'b0, D_MAX}) begin
                            duty_n  = D_MAX;
                            state_n = RUN;
                        end else begin
                            duty_n = duty_up[PWM_BITS-1:0];
                        end
                    end else begin
                        ramp_n = ramp_cnt + 1'b1;
                    end
                end else begin
                    duty_n = D_MAX;
                end
            end
            DECEL: begin
                if (bus.ms) begin
                    duty_n  = '0;
                    brake_n = 1'b1;
                    state_n = IDLE;
                end else if (duty == '0 || (ramp_tick && duty <= D_STEP)) begin
                    // motor is stopped: reverse, resume, or park
                    duty_n = '0;
                    ramp_n = '0;
                    if (req_valid && req_dir != dir) begin
                        dir_n   = req_dir;
                        dead_n  = '0;
                        brake_n = 1'b0;
                        state_n = DEAD;
                    end else if (req_valid) begin
                        stall_n = '0;
                        state_n = ACCEL;
                    end else begin
                        brake_n = 1'b1;
                        state_n = IDLE;
                    end
                end else if (ramp_tick) begin
                    duty_n = duty - D_STEP;
                    ramp_n = '0;
                end else begin
                    ramp_n = ramp_cnt + 1'b1;
                end
            end
            default: begin
                duty_n  = '0;
                brake_n = 1'b1;
                fault_n = 1'b1;
                state_n = FAULT;
            end
        endcase

        // encoder tracking uses the direction currently driven on the bridge
        if (bus.enc_pulse && state != FAULT) begin
            stall_n = '0;
            if (dir) begin
                if (position != P_OPEN) pos_n = position + 1'b1;
            end else if (position != '0) begin
                pos_n = position - 1'b1;
            end
        end

        limit_hit = bus.enc_pulse && state != FAULT && pos_n != position &&
                    (dir ? pos_n == P_OPEN : pos_n == '0);
        if (limit_hit) begin
            duty_n  = '0;
            brake_n = 1'b1;
            state_n = IDLE;
        end

        stall_hit = (state == ACCEL || state == RUN) && !bus.enc_pulse && stall_cnt == S_LAST;
        if (stall_hit) begin
            duty_n  = '0;
            brake_n = 1'b1;
            fault_n = 1'b1;
            state_n = FAULT;
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            duty        <= '0;
            cnt         <= '0;
            ramp_cnt    <= '0;
            dead_cnt    <= '0;
            stall_cnt   <= '0;
            position    <= '0;
            pwm         <= 1'b0;
            dir         <= 1'b0;
            brake       <= 1'b1;
            fault       <= 1'b0;
            door_opened <= 1'b0;
            door_closed <= 1'b1;
        end else begin
            state       <= state_n;
            duty        <= duty_n;
            cnt         <= cnt_n;
            ramp_cnt    <= ramp_n;
            dead_cnt    <= dead_n;
            stall_cnt   <= stall_n;
            position    <= pos_n;
            pwm         <= (cnt_n < duty_n);
            dir         <= dir_n;
            brake       <= brake_n;
            fault       <= fault_n;
            door_opened <= (pos_n == P_OPEN);
            door_closed <= (pos_n == '0);
        end
    end

    assign bus.pwm         = pwm;
    assign bus.dir         = dir;
    assign bus.brake       = brake;
    assign bus.fault       = fault;
    assign bus.position    = position;
    assign bus.door_opened = door_opened;
    assign bus.door_closed = door_closed;
endmodule

// File: tb/tb_door_motor_driver.sv
// Directed bench for door_motor_driver: open, stop, reversal, close, stall, reset.
module tb_door_motor_driver;
    localparam int S_IDLE  = 0;
    localparam int S_DEAD  = 1;
    localparam int S_ACCEL = 2;
    localparam int S_RUN   = 3;
    localparam int S_DECEL = 4;
    localparam int S_FAULT = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   enc_en = 0;
    int   enc_ph = 0;
    int   npulse = 0;

    door_motor_if ifc ();
    door_motor_driver dut (.clk(clk), .rst(rst), .bus(ifc.slave));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // advance n cycles; inputs change 1 time unit after each rising edge
    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (enc_en != 0) begin
                enc_ph++;
                if (enc_ph >= 8) begin
                    enc_ph = 0;
                    ifc.enc_pulse = 1'b1;
                    npulse++;
                end else begin
                    ifc.enc_pulse = 1'b0;
                end
            end else begin
                ifc.enc_pulse = 1'b0;
            end
        end
    endtask

    task automatic enc_start();
        enc_en = 1;
        enc_ph = 0;
        npulse = 0;
    endtask

    initial begin
        int k;
        int hi;
        int bad;
        ifc.mo = 0; ifc.mc = 0; ifc.ms = 0; ifc.enc_pulse = 0;

        // 1: reset state
        cyc(3);
        rst = 1'b1;
        cyc(2);
        chk("rst_pwm", ifc.pwm, 0);
        chk("rst_brake", ifc.brake, 1);
        chk("rst_closed", ifc.door_closed, 1);
        chk("rst_opened", ifc.door_opened, 0);
        chk("rst_fault", ifc.fault, 0);
        chk("rst_pos", ifc.position, 0);
        chk("rst_dir", ifc.dir, 0);
        chk("rst_state", dut.state, S_IDLE);

        // 2: full open
        ifc.mo = 1;
        cyc(1);
        chk("open_dir", ifc.dir, 1);
        chk("open_brake", ifc.brake, 0);
        chk("open_dead", dut.state, S_DEAD);
        enc_start();
        bad = 0;
        for (int i = 0; i < 31; i++) begin
            cyc(1);
            if (ifc.pwm !== 1'b0 || dut.state !== 3'(S_DEAD)) bad++;
        end
        chk("dead_pwm_low", bad, 0);
        cyc(1);
        chk("accel_entry", dut.state, S_ACCEL);
        chk("accel_duty0", dut.duty, 0);
        cyc(64);
        chk("duty_16", dut.duty, 16);
        cyc(64);
        chk("duty_32", dut.duty, 32);
        cyc(895);
        chk("duty_240", dut.duty, 240);
        chk("still_accel", dut.state, S_ACCEL);
        cyc(1);
        chk("duty_255", dut.duty, 255);
        chk("run_entry", dut.state, S_RUN);
        hi = 0;
        for (int i = 0; i < 256; i++) begin
            cyc(1);
            if (ifc.pwm === 1'b1) hi++;
        end
        chk("run_pwm_high", hi, 255);
        k = 0;
        while (ifc.door_opened !== 1'b1 && k < 10000) begin cyc(1); k++; end
        enc_en = 0;
        chk("opened", ifc.door_opened, 1);
        chk("open_pulses", npulse, 1000);
        chk("open_pos", ifc.position, 1000);
        chk("open_pwm", ifc.pwm, 0);
        chk("open_brake1", ifc.brake, 1);
        chk("open_idle", dut.state, S_IDLE);
        cyc(100);
        chk("no_restart", dut.state, S_IDLE);
        chk("no_restart_brake", ifc.brake, 1);
        ifc.mo = 0;
        cyc(2);

        // 3: close, emergency stop at 700
        ifc.mc = 1;
        cyc(1);
        chk("close_dir", ifc.dir, 0);
        chk("close_dead", dut.state, S_DEAD);
        enc_start();
        k = 0;
        while (npulse < 300 && k < 5000) begin cyc(1); k++; end
        chk("close_run", dut.state, S_RUN);
        ifc.ms = 1;
        enc_en = 0;
        cyc(1);
        chk("ms_idle", dut.state, S_IDLE);
        chk("ms_duty", dut.duty, 0);
        chk("ms_brake", ifc.brake, 1);
        chk("ms_pwm", ifc.pwm, 0);
        chk("ms_pos", ifc.position, 700);
        cyc(20);
        chk("ms_pos_hold", ifc.position, 700);

        // 4: restart closing, reach RUN, then reverse
        ifc.ms = 0;
        cyc(1);
        chk("reclose_dead", dut.state, S_DEAD);
        enc_start();
        cyc(32);
        chk("reclose_accel", dut.state, S_ACCEL);
        cyc(1024);
        chk("reclose_run", dut.state, S_RUN);
        chk("reclose_duty", dut.duty, 255);
        ifc.mc = 0; ifc.mo = 1;
        cyc(1);
        chk("rev_decel", dut.state, S_DECEL);
        chk("rev_duty255", dut.duty, 255);
        cyc(64);
        chk("rev_duty239", dut.duty, 239);
        cyc(959);
        chk("rev_duty15", dut.duty, 15);
        chk("rev_still_decel", dut.state, S_DECEL);
        cyc(1);
        chk("rev_dead", dut.state, S_DEAD);
        chk("rev_duty0", dut.duty, 0);
        chk("rev_dir", ifc.dir, 1);
        chk("rev_brake", ifc.brake, 0);
        cyc(32);
        chk("rev_accel", dut.state, S_ACCEL);
        chk("rev_accel_dir", ifc.dir, 1);
        ifc.ms = 1;
        enc_en = 0;
        cyc(1);
        chk("rev_stop", dut.state, S_IDLE);

        // close fully
        ifc.ms = 0; ifc.mo = 0; ifc.mc = 1;
        cyc(1);
        chk("fin_dir", ifc.dir, 0);
        enc_start();
        k = 0;
        while (ifc.door_closed !== 1'b1 && k < 20000) begin cyc(1); k++; end
        enc_en = 0;
        chk("closed", ifc.door_closed, 1);
        chk("closed_pos", ifc.position, 0);
        chk("closed_idle", dut.state, S_IDLE);
        chk("closed_brake", ifc.brake, 1);
        chk("closed_pwm", ifc.pwm, 0);
        chk("closed_opened", ifc.door_opened, 0);
        ifc.mc = 0;
        cyc(2);

        // 5: stall fault with no encoder pulses
        ifc.mo = 1;
        cyc(1);
        cyc(32);
        chk("stall_accel", dut.state, S_ACCEL);
        cyc(4095);
        chk("stall_not_yet", ifc.fault, 0);
        cyc(1);
        chk("stall_fault", ifc.fault, 1);
        chk("stall_brake", ifc.brake, 1);
        chk("stall_pwm", ifc.pwm, 0);
        chk("stall_state", dut.state, S_FAULT);
        ifc.mo = 0; ifc.mc = 1;
        enc_start();
        cyc(20);
        ifc.mc = 0; ifc.mo = 1;
        cyc(20);
        enc_en = 0;
        chk("fault_sticky", ifc.fault, 1);
        chk("fault_pos", ifc.position, 0);
        chk("fault_brake", ifc.brake, 1);
        chk("fault_state", dut.state, S_FAULT);

        // 6: asynchronous reset mid-RUN
        ifc.mo = 0;
        rst = 1'b0;
        cyc(2);
        chk("rst2_fault", ifc.fault, 0);
        rst = 1'b1;
        ifc.mo = 1;
        cyc(1);
        enc_start();
        cyc(32 + 1024);
        chk("rst_run", dut.state, S_RUN);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_pwm", ifc.pwm, 0);
        chk("arst_brake", ifc.brake, 1);
        chk("arst_pos", ifc.position, 0);
        chk("arst_closed", ifc.door_closed, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/door_motor_driver.md
Name: door_motor_driver

Overview:
- Downstream stage of the sliding-door controller FSM. Consumes its one-hot-ish motor commands (mo/mc/ms) and drives the door motor bridge: direction, PWM with ramped duty, brake and reversal dead time.
- Tracks door position from a motor encoder strobe and produces the door_opened/door_closed limit feedback that the controller FSM consumes.
- Detects motor stall and latches a sticky fault.

Parameters:
PWM_BITS, 8, PWM counter and duty width
DUTY_MAX, 255, full-speed duty
RAMP_STEP, 16, duty increment/decrement per ramp tick
RAMP_DIV, 64, clk cycles per ramp tick
DEAD_CYCLES, 32, bridge-off cycles before driving in a newly latched direction
POS_BITS, 10, position counter width
POS_OPEN, 1000, encoder count at fully open
STALL_CYCLES, 4096, cycles with no enc_pulse in ACCEL/RUN that trigger a fault

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-low reset
mo  input  1  open command (held while the controller is opening)
mc  input  1  close command (held while the controller is closing)
ms  input  1  stop command (held while the controller is stopped)
enc_pulse  input  1  single-cycle synchronous encoder strobe, one per position count
pwm  output  1  motor bridge PWM
dir  output  1  1 = open direction, 0 = close direction
brake  output  1  1 = bridge shorted/brake engaged
door_opened  output  1  position == POS_OPEN
door_closed  output  1  position == 0
fault  output  1  sticky stall fault
position  output  POS_BITS  current door position

Behaviour:
- Reset values (asynchronous, immediate): state IDLE, duty 0, pwm 0, dir 0, brake 1, position 0, door_closed 1, door_opened 0, fault 0, all internal counters 0. Power-up position is defined as closed.
- All outputs are registered. A command change is reflected on outputs one cycle after it is sampled.
- Command decode:
  - ms has priority over everything.
  - mo and mc both high is treated as no command.
  - The requested direction is open for mo, close for mc.
- PWM generation: a free-running PWM_BITS counter drives pwm = (cnt < duty). With duty 0, pwm is constantly low.
- State IDLE: duty 0, brake 1.
  - On mo with position != POS_OPEN, or mc with position != 0: latch dir, set brake 0, go to DEAD.
  - A command whose target limit is already reached is ignored.
- State DEAD: duty 0, brake 0, counts DEAD_CYCLES, then goes to ACCEL.
  - If the requested direction changes during DEAD: latch the new dir and restart the count.
  - On ms or no command: go to IDLE.
- State ACCEL: every RAMP_DIV cycles, duty += RAMP_STEP, saturating at DUTY_MAX. On reaching DUTY_MAX, go to RUN.
  - The ramp prescaler clears on entry to ACCEL and DECEL.
  - From 0, DUTY_MAX is reached after 16 ticks = 1024 cycles with default parameters.
- State RUN: duty = DUTY_MAX.
- Exits from ACCEL and RUN:
  - ms: duty 0, brake 1, go to IDLE on the next cycle. This is an immediate stop with no ramp.
  - No command, or the opposite command: go to DECEL.
- State DECEL: every RAMP_DIV cycles, duty -= RAMP_STEP, saturating at 0. On duty == 0:
  - If the opposite command is pending: latch the new dir and go to DEAD.
  - If the same command has been re-asserted: go to ACCEL from 0.
  - Otherwise: go to IDLE with brake 1.
  - ms during DECEL: immediate stop to IDLE.
- Position counter:
  - On enc_pulse in any state except FAULT: increment if dir = 1, else decrement.
  - The counter saturates at POS_OPEN and at 0.
  - door_opened and door_closed are registered compares of the updated position.
- Limit stop: if an enc_pulse moves position to POS_OPEN while dir = 1, or to 0 while dir = 0, the block sets duty 0, brake 1 and goes to IDLE in the same cycle that the flag asserts.
- Stall detection:
  - The stall counter clears on entry to ACCEL and on every enc_pulse, and counts only in ACCEL and RUN.
  - When it reaches STALL_CYCLES: go to FAULT.
- State FAULT: duty 0, brake 1, fault 1. All commands and encoder pulses are ignored. The only exit is rst.
- Simultaneous events, in priority order: rst > stall fault > limit stop > ms > direction/command change > ramp tick.

Test Plan:
1. Release rst with no commands -> pwm 0, brake 1, door_closed 1, door_opened 0, fault 0, position 0, dir 0.
2. Hold mo, enc_pulse every 8 cycles:
   - dir 1 and brake 0 one cycle after mo; 32 cycles with pwm 0.
   - Duty then steps 16, 32, ... every 64 cycles, reaching 255 at 1024 cycles.
   - On the 1000th pulse: door_opened 1, pwm 0, brake 1, state IDLE.
   - mo still high afterwards causes no restart.
3. From open, hold mc and assert ms after 300 pulses -> next cycle duty 0 and brake 1; position holds at 700. Releasing ms and re-asserting mc -> DEAD then ACCEL, and position decrements to 0 with door_closed 1.
4. In RUN closing (duty 255), switch mc to mo -> duty ramps 255 to 0 over 16 ticks (1024 cycles), then 32 dead cycles, then ACCEL with dir 1.
5. Hold mo with no enc_pulse -> fault 1 exactly 4096 cycles after ACCEL entry, brake 1, pwm 0. Later mo/mc toggles are ignored until rst.
6. Assert rst mid-RUN -> pwm 0, brake 1, position 0 immediately, without waiting for a clock edge.
